// File: rtl/mul_div_pkg.sv
// Shared encodings for the mul/div execute sequencer: op bit positions,
// controller states and the divide-by-zero quotient.
package mul_div_pkg;

  localparam int OP_MUL_W   = 0;
  localparam int OP_MULH_W  = 1;
  localparam int OP_MULH_WU = 2;
  localparam int OP_DIV_W   = 3;
  localparam int OP_MOD_W   = 4;
  localparam int OP_DIV_WU  = 5;
  localparam int OP_MOD_WU  = 6;
  localparam int OP_RSVD_LO = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_DIV_WAIT = 3'd3,
    ST_RESP     = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_result_sel.sv
// Picks the 32-bit writeback value from the unit outputs according to the
// latched op; also supplies the architectural divide-by-zero results.
module mul_div_result_sel
  import mul_div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 10
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [2*XLEN-1:0] res64_i,
  input  logic [XLEN-1:0]   quot_i,
  input  logic [XLEN-1:0]   rem_i,
  input  logic [XLEN-1:0]   src1_i,
  input  logic              div0_i,
  output logic [XLEN-1:0]   result_o
);

  always_comb begin
    result_o = '0;
    if (|op_i[OP_W-1:OP_RSVD_LO]) begin
      result_o = '0;
    end else if (op_i[OP_MUL_W]) begin
      result_o = res64_i[XLEN-1:0];
    end else if (op_i[OP_MULH_W] | op_i[OP_MULH_WU]) begin
      result_o = res64_i[2*XLEN-1:XLEN];
    end else if (op_i[OP_DIV_W] | op_i[OP_DIV_WU]) begin
      result_o = div0_i ? XLEN'(DIV0_QUOT) : quot_i;
    end else if (op_i[OP_MOD_W] | op_i[OP_MOD_WU]) begin
      // x mod 0 returns the dividend unchanged
      result_o = div0_i ? src1_i : rem_i;
    end
  end

endmodule

// File: rtl/mul_div_ctrl.sv
// Execute-stage sequencer for the shared multi-cycle multiplier/divider:
// one op in flight, held operands, result parked until writeback takes it.
module mul_div_ctrl
  import mul_div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [XLEN-1:0]   req_src1,
  input  logic [XLEN-1:0]   req_src2,
  output logic              mul_start,
  output logic              mul_signed,
  output logic [XLEN-1:0]   mul_x,
  output logic [XLEN-1:0]   mul_y,
  input  logic              mul_done,
  input  logic [2*XLEN-1:0] mul_res64,
  output logic              div_start,
  output logic              div_signed,
  output logic [XLEN-1:0]   div_x,
  output logic [XLEN-1:0]   div_y,
  input  logic              div_done,
  input  logic [XLEN-1:0]   div_quot,
  input  logic [XLEN-1:0]   div_rem,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_result,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [XLEN-1:0]   src1_q, src1_d;
  logic [XLEN-1:0]   src2_q, src2_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              op_rsvd;
  logic              op_mul;
  logic              op_div;
  logic              src2_zero;
  logic              launch_unit;
  logic              unit_done;
  logic [XLEN-1:0]   sel_result;

  assign op_rsvd     = |op_q[OP_W-1:OP_RSVD_LO];
  assign op_mul      = !op_rsvd && (|op_q[OP_MULH_WU:OP_MUL_W]);
  assign op_div      = !op_rsvd && !op_mul && (|op_q[OP_MOD_WU:OP_DIV_W]);
  assign src2_zero   = (src2_q == '0);
  assign launch_unit = op_mul || (op_div && !src2_zero);
  assign unit_done   = op_mul ? mul_done : div_done;

  mul_div_result_sel #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_result_sel (
    .op_i     (op_q),
    .res64_i  (mul_res64),
    .quot_i   (div_quot),
    .rem_i    (div_rem),
    .src1_i   (src1_q),
    .div0_i   (src2_zero),
    .result_o (sel_result)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    result_d   = result_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mul_start  = 1'b0;
    div_start  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          op_d    = req_op;
          src1_d  = req_src1;
          src2_d  = req_src2;
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        mul_start = op_mul;
        div_start = op_div && !src2_zero;
        if (!launch_unit) begin
          result_d = sel_result;
        end
        // Nothing to drain when no unit was started (div-by-zero, reserved op)
        if (flush) begin
          state_d = launch_unit ? ST_DRAIN : ST_IDLE;
        end else if (op_mul) begin
          state_d = ST_MUL_WAIT;
        end else if (launch_unit) begin
          state_d = ST_DIV_WAIT;
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_MUL_WAIT: begin
        if (mul_done) begin
          result_d = sel_result;
          state_d  = flush ? ST_IDLE : ST_RESP;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DIV_WAIT: begin
        if (div_done) begin
          result_d = sel_result;
          state_d  = flush ? ST_IDLE : ST_RESP;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (unit_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
    end
  end

  // Operand registers only change on accept, so they stay stable until done.
  assign mul_x       = src1_q;
  assign mul_y       = src2_q;
  assign div_x       = src1_q;
  assign div_y       = src2_q;
  assign mul_signed  = op_q[OP_MUL_W] | op_q[OP_MULH_W];
  assign div_signed  = op_q[OP_DIV_W] | op_q[OP_MOD_W];
  assign resp_result = result_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Randomized bench for mul_div_ctrl with latency-programmable unit models
// and an arithmetic reference model of the op set.
module tb_mul_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        mul_start, mul_signed;
  logic [31:0] mul_x, mul_y;
  logic        mul_done;
  logic [63:0] mul_res64;
  logic        div_start, div_signed;
  logic [31:0] div_x, div_y;
  logic        div_done;
  logic [31:0] div_quot, div_rem;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  logic        mul_done_m, div_done_m, spur_mul, spur_div;
  int          mul_lat, div_lat, mul_cnt, div_cnt;
  int          n_chk, n_pass;

  assign mul_done = mul_done_m | spur_mul;
  assign div_done = div_done_m | spur_div;

  always #5 clk = ~clk;

  mul_div_ctrl dut (
    .clk (clk), .resetn (resetn), .flush (flush),
    .req_valid (req_valid), .req_ready (req_ready), .req_op (req_op),
    .req_src1 (req_src1), .req_src2 (req_src2),
    .mul_start (mul_start), .mul_signed (mul_signed), .mul_x (mul_x), .mul_y (mul_y),
    .mul_done (mul_done), .mul_res64 (mul_res64),
    .div_start (div_start), .div_signed (div_signed), .div_x (div_x), .div_y (div_y),
    .div_done (div_done), .div_quot (div_quot), .div_rem (div_rem),
    .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_result (resp_result),
    .busy (busy)
  );

  // Unit models: done pulses lat cycles after the start cycle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_cnt <= 0; mul_done_m <= 1'b0; mul_res64 <= '0;
      div_cnt <= 0; div_done_m <= 1'b0; div_quot <= '0; div_rem <= '0;
    end else begin
      mul_done_m <= 1'b0;
      div_done_m <= 1'b0;
      if (mul_start) begin
        mul_cnt <= mul_lat - 1;
        if (mul_signed) mul_res64 <= {{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y};
        else            mul_res64 <= {32'd0, mul_x} * {32'd0, mul_y};
      end else if (mul_cnt > 0) begin
        mul_cnt <= mul_cnt - 1;
        if (mul_cnt == 1) mul_done_m <= 1'b1;
      end
      if (div_start) begin
        div_cnt <= div_lat - 1;
        if (div_signed) begin
          div_quot <= $signed(div_x) / $signed(div_y);
          div_rem  <= $signed(div_x) % $signed(div_y);
        end else begin
          div_quot <= div_x / div_y;
          div_rem  <= div_x % div_y;
        end
      end else if (div_cnt > 0) begin
        div_cnt <= div_cnt - 1;
        if (div_cnt == 1) div_done_m <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op[9:7] != 3'd0) return 32'd0;
    if (op[0]) begin p = sa * sb; return p[31:0];  end
    if (op[1]) begin p = sa * sb; return p[63:32]; end
    if (op[2]) begin p = ua * ub; return p[63:32]; end
    if (op[6:3] != 4'd0 && b == 32'd0) return (op[3] | op[5]) ? 32'hFFFF_FFFF : a;
    if (op[3]) begin p = sa / sb; return p[31:0]; end
    if (op[4]) begin p = sa % sb; return p[31:0]; end
    if (op[5]) begin p = ua / ub; return p[31:0]; end
    if (op[6]) begin p = ua % ub; return p[31:0]; end
    return 32'd0;
  endfunction

  task automatic run_op(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input bit fl_resp);
    logic [31:0] exp_res, held;
    int          cyc, exp_lat;
    bit          l_mul, l_div, stray;
    exp_res = ref_result(op, a, b);
    l_mul   = (op[9:7] == 3'd0) && (op[2:0] != 3'd0);
    l_div   = (op[9:7] == 3'd0) && !l_mul && (op[6:3] != 4'd0) && (b != 32'd0);
    exp_lat = (l_mul || l_div) ? 2 + lat : 2;
    mul_lat = lat;
    div_lat = lat;
    @(negedge clk);
    chk("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = 10'($urandom); req_src1 = $urandom; req_src2 = $urandom;
    chk("mul_start", mul_start, l_mul);
    chk("div_start", div_start, l_div);
    if (l_mul) begin
      chk("mul_signed", mul_signed, op[0] | op[1]);
      chk("mul_x", mul_x, a);
      chk("mul_y", mul_y, b);
    end
    if (l_div) begin
      chk("div_signed", div_signed, op[3] | op[4]);
      chk("div_x", div_x, a);
      chk("div_y", div_y, b);
    end
    cyc = 1;
    stray = 1'b0;
    while (!resp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mul_start || div_start || busy !== 1'b1 || req_ready !== 1'b0) stray = 1'b1;
      if (l_div && (div_x !== a || div_y !== b)) stray = 1'b1;
    end
    chk("wait_phase", stray, 1'b0);
    chk("latency", cyc, exp_lat);
    chk("result", resp_result, exp_res);
    held = resp_result;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_result", resp_result, held);
      chk("hold_ready", req_ready, 1'b0);
    end
    req_valid = 1'b1;
    if (fl_resp) flush = 1'b1;
    else resp_ready = 1'b1;
    chk("no_same_cycle_accept", req_ready, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 1'b0);
    chk("back_idle", busy, 1'b0);
    chk("ready_back", req_ready, 1'b1);
  endtask

  // Flush fcyc cycles after accept; fcyc == lat+1 lands on the done cycle.
  task automatic flush_op(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int fcyc);
    int cyc;
    bit seen;
    mul_lat = lat;
    div_lat = lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < fcyc) begin
      @(negedge clk);
      cyc++;
    end
    seen = mul_done | div_done;
    chk("done_at_flush", seen, fcyc == lat + 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      chk("drain_busy", busy, 1'b1);
      chk("drain_ready", req_ready, 1'b0);
      chk("drain_resp", resp_valid, 1'b0);
      seen = mul_done | div_done;
      flush = 1'b1;
      req_valid = !seen;
      @(negedge clk);
    end
    flush = 1'b0; req_valid = 1'b0;
    chk("drain_done_seen", seen, 1'b1);
    chk("flush_idle", busy, 1'b0);
    chk("flush_ready", req_ready, 1'b1);
    chk("flush_no_resp", resp_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_starts"}, {mul_start, div_start, mul_signed, div_signed}, 4'd0);
    chk({tag, "_operands"}, {mul_x, div_y}, 64'd0);
    chk({tag, "_result"}, resp_result, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  op;
    logic [31:0] a, b;
    int          k;
    n_chk = 0; n_pass = 0;
    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_src1 = '0; req_src2 = '0; resp_ready = 1'b0;
    spur_mul = 1'b0; spur_div = 1'b0; mul_lat = 3; div_lat = 3;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    run_op(10'b0000000001, 32'd7, 32'hFFFF_FFFD, 3, 0, 1'b0);
    run_op(10'b0000000100, 32'hFFFF_FFFF, 32'd2, 2, 0, 1'b0);
    run_op(10'b0000000010, 32'hFFFF_FFFF, 32'd2, 4, 1, 1'b0);
    run_op(10'b0000001000, 32'hFFFF_FFF9, 32'd2, 3, 0, 1'b0);
    run_op(10'b0000010000, 32'hFFFF_FFF9, 32'd2, 5, 0, 1'b0);
    run_op(10'b0000100000, 32'hFFFF_FFF9, 32'd2, 2, 0, 1'b0);
    run_op(10'b0000001000, 32'h0000_1234, 32'd0, 3, 0, 1'b0);
    run_op(10'b0000010000, 32'h0000_1234, 32'd0, 3, 3, 1'b0);
    run_op(10'b0010000000, 32'h5, 32'h6, 3, 0, 1'b0);
    run_op(10'b0000000000, 32'h5, 32'h6, 3, 2, 1'b1);

    // flush while waiting, on the done cycle, and during launch
    flush_op(10'b0000000001, 32'd9, 32'd9, 6, 4);
    run_op(10'b0000000001, 32'd9, 32'd9, 3, 0, 1'b0);
    flush_op(10'b0001000000, 32'd100, 32'd7, 3, 4);
    flush_op(10'b0000001000, 32'd100, 32'd7, 4, 1);
    run_op(10'b0001000000, 32'd100, 32'd7, 2, 0, 1'b0);

    // flush together with req_valid in idle, and stray done pulses
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 10'd1;
    spur_mul = 1'b1; spur_div = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; spur_mul = 1'b0; spur_div = 1'b0;
    chk("flush_wins", busy, 1'b0);
    chk("spurious_done", resp_valid, 1'b0);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 8);
      if (k < 7)       op = 10'(1 << k);
      else if (k == 7) op = 10'(1 << $urandom_range(7, 9));
      else             op = 10'd0;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) b = b % 32'd16;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(op, a, b, $urandom_range(2, 6), $urandom_range(0, 3), $urandom_range(0, 5) == 0);
    end

    // asynchronous reset in the middle of a divide
    mul_lat = 6; div_lat = 6;
    @(negedge clk);
    req_valid = 1'b1; req_op = 10'b0000001000; req_src1 = 32'd50; req_src2 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    resetn = 1'b1;
    run_op(10'b0000010000, 32'd50, 32'd3, 4, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_div_ctrl.md
Name: mul_div_ctrl

Overview:
Execute-stage sequencer for the shared multi-cycle multiplier and divider. Accepts one mul/div op at a time from EXE via valid/ready, launches the correct unit with held operands, and waits for its done. Selects the 32-bit result slice, and holds it until writeback accepts. Handles pipeline flush while a unit is busy by draining the in-flight operation and discarding it.

Parameters:
XLEN, 32, operand/result width
OP_W, 10, width of mul_div_op (bit-per-op encoding)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (exception/ertn); cancels current op
req_valid  in  1  EXE presents an op
req_ready  out  1  controller can accept
req_op  in  OP_W  bit0 MUL.W, bit1 MULH.W, bit2 MULH.WU, bit3 DIV.W, bit4 MOD.W, bit5 DIV.WU, bit6 MOD.WU, bits9:7 reserved
req_src1  in  XLEN  operand x / dividend
req_src2  in  XLEN  operand y / divisor
mul_start  out  1  one-cycle launch pulse to multiplier
mul_signed  out  1  signed multiply
mul_x, mul_y  out  XLEN  multiplier operands (registered)
mul_done  in  1  multiplier result valid
mul_res64  in  2*XLEN  product
div_start  out  1  one-cycle launch pulse to divider
div_signed  out  1  signed divide
div_x, div_y  out  XLEN  divider operands (registered)
div_done  in  1  divider result valid
div_quot, div_rem  in  XLEN  quotient, remainder
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts
resp_result  out  XLEN  selected result
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1. Reset mid-operation aborts the op immediately with no drain; unit reset is external.
- States: IDLE, LAUNCH, MUL_WAIT, DIV_WAIT, RESP, DRAIN.
- IDLE: req_ready=1. Accept on req_valid & req_ready & !flush, latching op, src1, src2 → LAUNCH. If flush is asserted with req_valid in the same cycle, flush wins and nothing is accepted.
- LAUNCH (1 cycle): operand regs drive mul_x/y or div_x/y, held stable until done.
  - mul op: mul_start=1, mul_signed=op[0]|op[1] → MUL_WAIT.
  - div op with src2!=0: div_start=1, div_signed=op[3]|op[4] → DIV_WAIT.
  - div op with src2==0: units not launched → RESP with quotient 0xFFFFFFFF, remainder = src1.
  - reserved/zero op: → RESP with result 0.
  - Latency from accept to resp_valid = 2 + unit latency.
- MUL_WAIT/DIV_WAIT: done is sampled only in the matching state. On done, register result → RESP.
  - MUL.W → res64[31:0]; MULH.W/MULH.WU → res64[63:32].
  - DIV → quot; MOD → rem.
- RESP: resp_valid=1, resp_result stable. On resp_ready → IDLE; req_ready rises the following cycle, so there is no same-cycle re-accept.
- flush:
  - In LAUNCH (start already pulsing) or *_WAIT without done → DRAIN.
  - In *_WAIT with done the same cycle → IDLE; result discarded.
  - In RESP → IDLE; resp_valid drops next cycle.
- DRAIN: req_ready=0, resp_valid=0. Wait for done of the unit launched → IDLE. Further flush in DRAIN has no effect.
- start pulses are exactly one cycle; never asserted outside LAUNCH.
- A spurious done in a state not expecting it is ignored.

Decomposition:
- Package mul_div_pkg holds:
  - op bit index constants (OP_MUL_W … OP_MOD_WU);
  - state encoding constants;
  - DIV0_QUOT = 32'hFFFFFFFF.
- One natural combinational sub-module, mul_div_result_sel: maps latched op, res64, quot, rem and the div0 flag to the 32-bit result.

Test Plan:
- MUL.W src1=7, src2=0xFFFFFFFD, mul model latency 3 → mul_start one cycle after accept, mul_signed=1, resp_result=0xFFFFFFEB at accept+5.
- MULH.WU 0xFFFFFFFF×2 → mul_signed=0, resp_result=0x00000001; MULH.W same operands → 0xFFFFFFFF.
- DIV.W 0xFFFFFFF9/2 → 0xFFFFFFFD; MOD.W same → 0xFFFFFFFF; DIV.WU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIV.W src2=0, src1=0x1234 → no div_start, resp_result=0xFFFFFFFF at accept+2; MOD.W → 0x00001234.
- flush two cycles into MUL_WAIT → busy stays 1, req_ready=0 until mul_done, then IDLE, no resp_valid; the next op completes correctly.
- resp_ready held low 3 cycles in RESP → resp_valid/result stable, req_valid ignored. resetn low mid-DIV_WAIT → all outputs at reset values immediately.
